// File: rtl/snn_aer_pkg.sv
// snn_aer_pkg: shared AER link types, defaults and constants
package snn_aer_pkg;
    localparam int IMAGE_SIZE = 256;
    localparam int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
    typedef logic [IMAGE_SIZE_BITS:0] aer_addr_t;
    typedef enum logic {IDLE, ACK_HI} aer_rx_state_t;
    localparam logic [15:0] EVT_TOTAL_MAX = 16'hFFFF;
endpackage

// File: rtl/aer_evt_fifo.sv
// aer_evt_fifo: synchronous first-word-fall-through event FIFO with registered head
module aer_evt_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int DEPTH_BITS = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PUSH,
    input  logic [WIDTH-1:0]      DIN,
    input  logic                  POP,
    output logic [WIDTH-1:0]      DOUT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DEPTH_BITS:0]   COUNT
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [DEPTH_BITS:0] count_nxt;
    logic wr_en, rd_en;

    assign EMPTY = COUNT == '0;
    assign FULL = COUNT == (DEPTH_BITS+1)'(DEPTH);
    assign rd_en = POP && !EMPTY;
    assign wr_en = PUSH && (!FULL || rd_en);
    assign rd_nxt = rd_en ? rd_ptr + 1'b1 : rd_ptr;

    // occupancy after this edge: a simultaneous push and pop cancel out
    always_comb begin
        count_nxt = (wr_en && !rd_en) ? COUNT + 1'b1 : (rd_en && !wr_en) ? COUNT - 1'b1 : COUNT;
    end

    // storage array, written at the tail
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= DIN;
    end

    // pointers, count and the head register; head holds its last value once empty
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
            DOUT   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            COUNT  <= count_nxt;
            if (count_nxt != '0) DOUT <= (wr_en && wr_ptr == rd_nxt) ? DIN : mem[rd_nxt];
        end
    end
endmodule

// File: rtl/aer_in_rx.sv
// aer_in_rx: 4-phase AER input receiver feeding a valid/ready event stream
module aer_in_rx #(
    parameter int IMAGE_SIZE = snn_aer_pkg::IMAGE_SIZE,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_DEPTH_BITS = $clog2(FIFO_DEPTH)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [IMAGE_SIZE_BITS:0]   AERIN_ADDR,
    input  logic                       AERIN_REQ,
    output logic                       AERIN_ACK,
    output logic [IMAGE_SIZE_BITS:0]   EVT_ADDR,
    output logic                       EVT_VALID,
    input  logic                       EVT_READY,
    output logic [FIFO_DEPTH_BITS:0]   FIFO_COUNT,
    output logic [15:0]                EVT_TOTAL
);
    import snn_aer_pkg::*;

    aer_rx_state_t state, state_nxt;
    logic req_sync_int, req_sync;
    logic push, pop, fifo_full, fifo_empty;

    assign EVT_VALID = !fifo_empty;
    assign pop = EVT_VALID && EVT_READY;

    // two-flop synchroniser for the asynchronous request
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_sync_int <= 1'b0;
            req_sync     <= 1'b0;
        end else begin
            req_sync_int <= AERIN_REQ;
            req_sync     <= req_sync_int;
        end
    end

    // capture when a request is pending and a slot is free, counting a same-cycle pop
    always_comb begin
        push = 1'b0;
        state_nxt = state;
        push = (state == IDLE) && req_sync && (!fifo_full || pop);
        state_nxt = push ? ACK_HI : (state == ACK_HI && !req_sync) ? IDLE : state;
    end

    // state register, registered acknowledge and saturating event counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            AERIN_ACK <= 1'b0;
            EVT_TOTAL <= '0;
        end else begin
            state     <= state_nxt;
            AERIN_ACK <= state_nxt == ACK_HI;
            if (push && EVT_TOTAL != EVT_TOTAL_MAX) EVT_TOTAL <= EVT_TOTAL + 1'b1;
        end
    end

    aer_evt_fifo #(
        .WIDTH(IMAGE_SIZE_BITS+1),
        .DEPTH(FIFO_DEPTH),
        .DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
        .CLK(CLK),
        .RST(RST),
        .PUSH(push),
        .DIN(AERIN_ADDR),
        .POP(pop),
        .DOUT(EVT_ADDR),
        .FULL(fifo_full),
        .EMPTY(fifo_empty),
        .COUNT(FIFO_COUNT)
    );
endmodule

// File: doc/aer_in_rx.md
Name: aer_in_rx

Overview:
- Receiving end of the 4-phase AER input link that carries pixel/neuron indices into the SNN core.
- Synchronises the asynchronous AERIN_REQ and latches AERIN_ADDR (bundled data).
- Returns AERIN_ACK and buffers received events in a small first-word-fall-through (FWFT) FIFO.
- Presents buffered events to the neuron-update logic as a valid/ready stream.
- Applies backpressure by withholding ACK while the FIFO is full; no event is ever dropped.

Parameters:
- IMAGE_SIZE, 256: number of addressable input neurons.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE): address MSB index; address bus is [IMAGE_SIZE_BITS:0].
- FIFO_DEPTH, 4: event buffer entries; must be a power of 2 and at least 2.
- FIFO_DEPTH_BITS, $clog2(FIFO_DEPTH): FIFO pointer width.

Ports:
- CLK  in  1  core clock.
- RST  in  1  reset; synchronous, active-high.
- AERIN_ADDR  in  [IMAGE_SIZE_BITS:0]  event address; guaranteed stable while AERIN_REQ is high.
- AERIN_REQ  in  1  asynchronous request from sender.
- AERIN_ACK  out  1  acknowledge to sender; registered.
- EVT_ADDR  out  [IMAGE_SIZE_BITS:0]  head-of-FIFO address.
- EVT_VALID  out  1  FIFO not empty.
- EVT_READY  in  1  consumer accepts head entry when EVT_VALID && EVT_READY.
- FIFO_COUNT  out  [FIFO_DEPTH_BITS:0]  current occupancy.
- EVT_TOTAL  out  16  count of events accepted since reset; saturates at 16'hFFFF.

Behaviour:
Reset (synchronous, on posedge CLK with RST=1):
- AERIN_ACK=0, state=IDLE, FIFO empty (EVT_VALID=0, FIFO_COUNT=0).
- EVT_ADDR=0, EVT_TOTAL=0, both synchroniser flops=0.
- RST overrides all other activity in that cycle.

Synchroniser:
- Two flops: REQ_sync_int <= AERIN_REQ; REQ_sync <= REQ_sync_int.
- The FSM uses only REQ_sync.

FSM states and transitions:
- IDLE, REQ_sync=1 and FIFO not full: push AERIN_ADDR, set AERIN_ACK<=1, increment EVT_TOTAL (saturating), go to ACK_HI.
- IDLE, REQ_sync=1 and FIFO full: stay in IDLE with ACK=0 (stall). Re-evaluate every cycle; capture on the first cycle the FIFO is not full, counting a same-cycle pop as freeing space.
- ACK_HI: hold ACK=1 until REQ_sync=0, then set AERIN_ACK<=0 and return to IDLE.
- AERIN_ADDR is sampled directly (not synchronised) at the push edge. It is valid because REQ has been high for at least 2 cycles.

Latency:
- AERIN_REQ rises before edge k.
- ACK and EVT_VALID go high after edge k+2.
- With REQ falling before edge m, ACK falls after edge m+2.
- A new request is accepted no earlier than one cycle after ACK falls.

FIFO:
- FWFT: EVT_ADDR equals the head entry whenever EVT_VALID=1; when empty, EVT_ADDR holds its last value.
- Pointers wrap modulo FIFO_DEPTH.
- FIFO_COUNT updates on the edge of a push or pop:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
- A push and pop in the same cycle are legal in every state, including full (the pop frees the slot) and empty (the push does not bypass; EVT_VALID rises next cycle).
- Pop while empty is ignored.

Reset mid-handshake:
- The FSM returns to IDLE and drops ACK.
- If the sender still holds REQ high after RST deasserts, that event is captured again. The sender must be reset in the same cycle, and the system reset guarantees this.

Decomposition:
- Shared package snn_aer_pkg holds:
  - IMAGE_SIZE / IMAGE_SIZE_BITS defaults
  - typedef aer_addr_t ([IMAGE_SIZE_BITS:0])
  - enum aer_rx_state_t {IDLE, ACK_HI}
  - constant EVT_TOTAL_MAX=16'hFFFF
- One sub-module, aer_evt_fifo: parameterised synchronous FWFT FIFO with push, pop, full, empty and count.
- The synchroniser, FSM and EVT_TOTAL counter stay in aer_in_rx.

Test Plan:
1. Single event: ADDR=9'h05A, raise REQ, lower it after ACK.
   - ACK rises exactly 3 edges after REQ; EVT_VALID=1 with EVT_ADDR=9'h05A; EVT_TOTAL=1.
   - ACK falls 3 edges after REQ falls.
2. Backpressure: EVT_READY=0, send 5 events with addresses 1..5.
   - The first 4 are acked and FIFO_COUNT=4; the 5th REQ stays unacked.
   - Raise EVT_READY for one cycle: the 5th is acked, and the consumer then reads 1,2,3,4,5 in order.
3. Full with simultaneous pop: FIFO full, REQ pending, EVT_READY=1 for one cycle.
   - Push and pop occur on the same edge; FIFO_COUNT stays 4; no address is lost or duplicated.
4. Pointer wrap: stream 10 events (0x000..0x009) with EVT_READY toggling randomly.
   - Output order matches input; FIFO_COUNT never exceeds 4 and never underflows.
5. Reset mid-handshake: assert RST while in ACK_HI with FIFO_COUNT=2.
   - After the reset edge: ACK=0, EVT_VALID=0, FIFO_COUNT=0, EVT_TOTAL=0.
   - After REQ is released and re-raised, a normal capture follows.
6. Saturation: preload EVT_TOTAL near the limit via force, or send 65 537 events.
   - EVT_TOTAL holds at 16'hFFFF.
